// File: rtl/modn_pkg.sv
// Shared constants for the modulo-N counter: seven-segment patterns {g..a}, active-low,
// and the prescaler width.
`default_nettype none

package modn_pkg;

  localparam int PRE_W = 16;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/seg7_digit.sv
// Decimal digit to active-low seven-segment pattern; non-decimal codes show blank.
`default_nettype none

module seg7_digit
  import modn_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/modn_counter.sv
// Prescaled up/down modulo-N counter with load, terminal-count pulse and
// two-digit seven-segment display outputs.
`default_nettype none

module modn_counter
  import modn_pkg::*;
#(
  parameter int MODULUS  = 12,
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [7:0]       led,
  output logic [7:0]       dac,
  output logic [6:0]       lseg,
  output logic [6:0]       hseg
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("modn_counter: MODULUS must be in 2..100");
  end
  if (WIDTH > 8 || (2 ** WIDTH) < MODULUS) begin : g_bad_width
    $error("modn_counter: WIDTH must be <= 8 and hold MODULUS-1");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("modn_counter: PRESCALE must be in 1..65535");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  // Load wins over stepping and restarts the prescale period; tc only on a wrap step.
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    step    = en && (pre_q == PRE_MAX);
    if (load) begin
      count_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
      pre_d   = '0;
    end else if (step) begin
      pre_d = '0;
      if (up) begin
        if (count_q == CNT_MAX) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = CNT_MAX;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end else if (en) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  logic [7:0] cnt8;
  logic [3:0] ones, tens;
  logic [6:0] hseg_raw;

  assign cnt8  = 8'(count_q);
  assign ones  = 4'(cnt8 % 8'd10);
  assign tens  = 4'(cnt8 / 8'd10);
  assign count = count_q;
  assign tc    = tc_q;
  assign led   = cnt8;
  assign dac   = cnt8;

  seg7_digit u_ones (
    .digit_i (ones),
    .seg_o   (lseg)
  );

  seg7_digit u_tens (
    .digit_i (tens),
    .seg_o   (hseg_raw)
  );

  assign hseg = (BLANK_LZ != 0 && tens == 4'd0) ? SEG_BLANK : hseg_raw;

endmodule

`default_nettype wire

// File: tb/tb_modn_counter.sv
// Bench for modn_counter: three parameterisations share one stimulus stream and
// are checked against an arithmetic reference model.
`default_nettype none

module tb_modn_counter;

  localparam int NI = 3;
  localparam int MODS [NI] = '{12, 12, 100};
  localparam int PSS  [NI] = '{1, 3, 1};
  localparam int WS   [NI] = '{4, 4, 7};
  localparam int BLS  [NI] = '{0, 0, 1};
  localparam logic [6:0] SEG_TAB [10] =
    '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       reset_n, en, up, load;
  logic [7:0] load_val;

  logic [3:0] cnt_a, cnt_b;
  logic [6:0] cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic [7:0] led_a, led_b, led_c, dac_a, dac_b, dac_c;
  logic [6:0] ls_a, ls_b, ls_c, hs_a, hs_b, hs_c;

  always #5 clk = ~clk;

  modn_counter #(.MODULUS(12), .WIDTH(4), .PRESCALE(1), .BLANK_LZ(0)) u_a (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .count(cnt_a), .tc(tc_a), .led(led_a), .dac(dac_a), .lseg(ls_a), .hseg(hs_a));

  modn_counter #(.MODULUS(12), .WIDTH(4), .PRESCALE(3), .BLANK_LZ(0)) u_b (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .count(cnt_b), .tc(tc_b), .led(led_b), .dac(dac_b), .lseg(ls_b), .hseg(hs_b));

  modn_counter #(.MODULUS(100), .WIDTH(7), .PRESCALE(1), .BLANK_LZ(1)) u_c (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val[6:0]),
    .count(cnt_c), .tc(tc_c), .led(led_c), .dac(dac_c), .lseg(ls_c), .hseg(hs_c));

  logic [7:0] obs_cnt [NI];
  logic       obs_tc  [NI];
  logic [7:0] obs_led [NI];
  logic [7:0] obs_dac [NI];
  logic [6:0] obs_ls  [NI];
  logic [6:0] obs_hs  [NI];

  assign obs_cnt[0] = {4'b0, cnt_a};
  assign obs_cnt[1] = {4'b0, cnt_b};
  assign obs_cnt[2] = {1'b0, cnt_c};
  assign obs_tc[0] = tc_a;   assign obs_tc[1] = tc_b;   assign obs_tc[2] = tc_c;
  assign obs_led[0] = led_a; assign obs_led[1] = led_b; assign obs_led[2] = led_c;
  assign obs_dac[0] = dac_a; assign obs_dac[1] = dac_b; assign obs_dac[2] = dac_c;
  assign obs_ls[0] = ls_a;   assign obs_ls[1] = ls_b;   assign obs_ls[2] = ls_c;
  assign obs_hs[0] = hs_a;   assign obs_hs[1] = hs_b;   assign obs_hs[2] = hs_c;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: count value, cycles spent in the current prescale period, wrap flag.
  int m_cnt [NI];
  int m_pre [NI];
  bit m_tc  [NI];

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0;
      m_pre[i] = 0;
      m_tc[i]  = 1'b0;
    end
  endfunction

  function automatic void model_update();
    int lv;
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 1'b0;
      end else if (load) begin
        lv = int'(load_val) % (1 << WS[i]);
        m_cnt[i] = (lv < MODS[i]) ? lv : MODS[i] - 1;
        m_pre[i] = 0;
        m_tc[i]  = 1'b0;
      end else if (!en) begin
        m_tc[i] = 1'b0;
      end else if (m_pre[i] == PSS[i] - 1) begin
        m_pre[i] = 0;
        m_cnt[i] = up ? (m_cnt[i] + 1) % MODS[i] : (m_cnt[i] + MODS[i] - 1) % MODS[i];
        m_tc[i]  = up ? (m_cnt[i] == 0) : (m_cnt[i] == MODS[i] - 1);
      end else begin
        m_pre[i] = m_pre[i] + 1;
        m_tc[i]  = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic load_value(input int v);
    load = 1'b1; load_val = 8'(v);
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'd0;
    model_reset();
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (obs_cnt[i] !== 8'd0 || obs_tc[i] !== 1'b0 || obs_led[i] !== 8'd0 ||
          obs_dac[i] !== 8'd0 || obs_ls[i] !== 7'h40 ||
          obs_hs[i] !== ((BLS[i] != 0) ? 7'h7F : 7'h40)) begin
        n_bad++;
        $display("FAIL reset inst%0d: got cnt=%0d tc=%0b led=%0d dac=%0d ls=%h hs=%h, expected zeros/ls=40",
                 i, obs_cnt[i], obs_tc[i], obs_led[i], obs_dac[i], obs_ls[i], obs_hs[i]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_count_up();
    en = 1'b1; up = 1'b1;
    for (int t = 0; t < 13; t++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (obs_cnt[i] !== 8'(m_cnt[i]) || obs_tc[i] !== m_tc[i]) begin
          n_bad++;
          $display("FAIL count_up inst%0d t%0d: got cnt=%0d tc=%0b, expected cnt=%0d tc=%0b",
                   i, t, obs_cnt[i], obs_tc[i], m_cnt[i], m_tc[i]);
        end
      end
      if (m_cnt[0] == 11) begin
        n_cmp++;
        if (hs_a !== 7'h79 || ls_a !== 7'h79) begin
          n_bad++;
          $display("FAIL seg_at_11: got hseg=%h lseg=%h, expected 79/79", hs_a, ls_a);
        end
      end
    end
  endtask

  task automatic test_count_down();
    en = 1'b1;
    load_value(0);
    up = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (t == 3) up = 1'b1;
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (obs_cnt[i] !== 8'(m_cnt[i]) || obs_tc[i] !== m_tc[i]) begin
          n_bad++;
          $display("FAIL count_down inst%0d t%0d: got cnt=%0d tc=%0b, expected cnt=%0d tc=%0b",
                   i, t, obs_cnt[i], obs_tc[i], m_cnt[i], m_tc[i]);
        end
      end
    end
  endtask

  task automatic test_prescale_gap();
    en = 1'b1; up = 1'b1;
    load_value(0);
    for (int t = 0; t < 16; t++) begin
      en = (t >= 1 && t < 6) ? 1'b0 : 1'b1;
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (obs_cnt[i] !== 8'(m_cnt[i]) || obs_tc[i] !== m_tc[i]) begin
          n_bad++;
          $display("FAIL prescale_gap inst%0d t%0d: got cnt=%0d tc=%0b, expected cnt=%0d tc=%0b",
                   i, t, obs_cnt[i], obs_tc[i], m_cnt[i], m_tc[i]);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_load();
    int vals [4] = '{7, 14, 11, 0};
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 4; k++) begin
      load_value(vals[k]);
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (obs_cnt[i] !== 8'(m_cnt[i]) || obs_tc[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL load inst%0d val%0d: got cnt=%0d tc=%0b, expected cnt=%0d tc=0",
                   i, vals[k], obs_cnt[i], obs_tc[i], m_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_display();
    logic [6:0] exp_l, exp_h;
    int v;
    en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      v = (k == 0) ? 5 : (k == 1) ? 99 : (k == 2) ? 10 : int'($urandom_range(0, 127));
      load_value(v);
      for (int i = 0; i < NI; i++) begin
        exp_l = SEG_TAB[m_cnt[i] % 10];
        exp_h = (BLS[i] != 0 && m_cnt[i] / 10 == 0) ? 7'h7F : SEG_TAB[m_cnt[i] / 10];
        n_cmp++;
        if (obs_led[i] !== 8'(m_cnt[i]) || obs_dac[i] !== 8'(m_cnt[i]) ||
            obs_ls[i] !== exp_l || obs_hs[i] !== exp_h) begin
          n_bad++;
          $display("FAIL display inst%0d cnt%0d: got led=%0d dac=%0d ls=%h hs=%h, expected led=dac=%0d ls=%h hs=%h",
                   i, m_cnt[i], obs_led[i], obs_dac[i], obs_ls[i], obs_hs[i], m_cnt[i], exp_l, exp_h);
        end
      end
    end
    load_value(99);
    en = 1'b1; up = 1'b1;
    tick();
    n_cmp++;
    if (cnt_c !== 7'd0 || tc_c !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_99: got cnt=%0d tc=%0b, expected cnt=0 tc=1", cnt_c, tc_c);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 4) != 0) ? up : ~up;
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (obs_cnt[i] !== 8'(m_cnt[i]) || obs_tc[i] !== m_tc[i] || m_cnt[i] >= MODS[i]) begin
          n_bad++;
          $display("FAIL random inst%0d t%0d: got cnt=%0d tc=%0b, expected cnt=%0d tc=%0b",
                   i, t, obs_cnt[i], obs_tc[i], m_cnt[i], m_tc[i]);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    bit reached = 1'b0;
    en = 1'b1; up = 1'b1;
    load_value(0);
    for (int t = 0; t < 40 && !reached; t++) begin
      tick();
      reached = (cnt_a == 4'd9);
    end
    n_cmp++;
    if (!reached) begin
      n_bad++;
      $display("FAIL async_wait: got cnt=%0d, expected to reach 9 within 40 cycles", cnt_a);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (obs_cnt[i] !== 8'd0 || obs_tc[i] !== 1'b0 || obs_ls[i] !== 7'h40) begin
        n_bad++;
        $display("FAIL async_reset inst%0d: got cnt=%0d tc=%0b ls=%h, expected cnt=0 tc=0 ls=40",
                 i, obs_cnt[i], obs_tc[i], obs_ls[i]);
      end
    end
    tick();
    #2;
    reset_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (obs_cnt[i] !== 8'(m_cnt[i]) || obs_tc[i] !== m_tc[i]) begin
          n_bad++;
          $display("FAIL post_reset inst%0d t%0d: got cnt=%0d tc=%0b, expected cnt=%0d tc=%0b",
                   i, t, obs_cnt[i], obs_tc[i], m_cnt[i], m_tc[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_prescale_gap();
    test_load();
    test_display();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modn_counter.md
MODN_COUNTER -- requirements
Module: modn_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 12: count sequence length; legal range 2..100.
REQ-002 SHALL have parameter WIDTH, default 4: count width; elaboration error if 2**WIDTH < MODULUS or WIDTH > 8.
REQ-003 SHALL have parameter PRESCALE, default 1: enabled cycles per count step; legal range 1..65535.
REQ-004 SHALL have parameter BLANK_LZ, default 0: 1 blanks the tens digit when it is zero.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1: count enable, feeds the prescaler.
REQ-008 SHALL have port up, input, 1: 1 counts up, 0 counts down.
REQ-009 SHALL have port load, input, 1: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH: value to load.
REQ-011 SHALL have port count, output, WIDTH: registered count.
REQ-012 SHALL have port tc, output, 1: registered terminal-count (wrap) pulse.
REQ-013 SHALL have port led, output, 8: count zero-extended.
REQ-014 SHALL have port dac, output, 8: count zero-extended.
REQ-015 SHALL have port lseg, output, 7: active-low ones-digit segments {g..a}.
REQ-016 SHALL have port hseg, output, 7: active-low tens-digit segments {g..a}.

Function
REQ-017 Prescaler SHALL be a 16-bit counter pre, 0..PRESCALE-1, advancing only when en=1; step = en & (pre==PRESCALE-1); pre wraps to 0 on step.
REQ-018 With en=0, pre, count and tc SHALL hold (tc drops to 0).
REQ-019 On step with up=1: count<MODULUS-1 -> count+1; count==MODULUS-1 -> 0.
REQ-020 On step with up=0: count>0 -> count-1; count==0 -> MODULUS-1.
REQ-021 tc SHALL be 1 for exactly the one cycle in which count first shows the wrapped value (0 up, MODULUS-1 down); otherwise 0.
REQ-022 load SHALL take priority over en/step: next count = load_val if load_val<MODULUS, else MODULUS-1; pre cleared to 0; tc=0 next cycle.
REQ-023 Direction change SHALL take effect on the next step; no skipped or repeated value.
REQ-024 count SHALL never hold a value >= MODULUS.
REQ-025 led, dac SHALL be combinational from count, zero latency.
REQ-026 lseg/hseg SHALL decode ones=count%10, tens=count/10, combinational from count; digits 0-9 standard active-low patterns (0=0x40, 1=0x79, ... 9=0x10); blank=0x7F.
REQ-027 With BLANK_LZ=1 and tens==0, hseg SHALL be 0x7F.

Reset
REQ-028 reset_n low SHALL asynchronously force count=0, pre=0, tc=0; hence led=dac=0, lseg=0x40, hseg=0x40 (0x7F if BLANK_LZ=1).
REQ-029 Reset released mid-count SHALL restart from 0 with full PRESCALE delay before the first step.

Structure
REQ-030 Package modn_pkg SHALL hold segment pattern constants SEG_0..SEG_9, SEG_BLANK and the prescaler width constant.
REQ-031 Digit decode SHALL be one sub-module seg7_digit (4-bit digit in, 7-bit active-low segments out), instantiated twice.

Verification
REQ-032 MODULUS=12, PRESCALE=1, up=1, en=1 from reset: count 0,1..11,0; tc=1 only in cycle count returns to 0; hseg/lseg at 11 = 0x79/0x79.
REQ-033 up=0 from 0: next count 11 with tc=1, then 10, 9; reversing at 9 -> 10.
REQ-034 PRESCALE=3: count advances every 3rd enabled cycle; en low 5 cycles mid-period -> step delayed by exactly 5 cycles.
REQ-035 load=1, load_val=7 with en=1 -> count=7, pre=0; load_val=14 -> count=11, tc=0.
REQ-036 reset_n pulled low asynchronously at count=9 -> count=0, tc=0, lseg=0x40 without waiting for clk.
REQ-037 MODULUS=100, WIDTH=7, BLANK_LZ=1: count 5 -> hseg=0x7F, lseg=0x12; 99 wraps to 0 with tc=1.
